// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI lane distributor.
package dsi_pkg;
  localparam int DSI_LANES_MAX   = 4;
  localparam int DSI_LP_FLAG_BIT = 4;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FINISH} distrib_state_t;

  // Byte count of a contiguous-from-bit-0 strobe.
  function automatic logic [2:0] strb_bytes(input logic [3:0] strb);
    if (strb[3])      return 3'd4;
    else if (strb[2]) return 3'd3;
    else if (strb[1]) return 3'd2;
    else if (strb[0]) return 3'd1;
    else              return 3'd0;
  endfunction
endpackage

// File: rtl/dsi_byte_buffer.sv
// Head-aligned byte FIFO: variable push (0-4) and pop (0-4) bytes per cycle.
// Exposes the post-update count and head so the caller can register beats.
module dsi_byte_buffer #(
  parameter  int BUF_BYTES  = 8,
  parameter  int HEAD_BYTES = 4,
  localparam int CW         = $clog2(BUF_BYTES + 1),
  localparam int AW         = $clog2(BUF_BYTES)
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic [2:0]                 push_n_i,
  input  logic [31:0]                push_data_i,
  input  logic [2:0]                 pop_n_i,
  output logic [CW-1:0]              count_o,
  output logic [CW-1:0]              nxt_count_o,
  output logic [HEAD_BYTES-1:0][7:0] nxt_head_o
);
  logic [BUF_BYTES-1:0][7:0] mem_q, mem_d;
  logic [CW-1:0]             count_q, count_d, keep;
  logic [3:0][7:0]           pdat;

  assign pdat    = push_data_i;
  assign keep    = count_q - CW'(pop_n_i);
  assign count_d = keep + CW'(push_n_i);

  // Survivors shift down by the pop amount; new bytes land right behind them.
  always_comb begin
    int src, ofs;
    src   = 0;
    ofs   = 0;
    mem_d = '0;
    for (int j = 0; j < BUF_BYTES; j++) begin
      src = j + int'(pop_n_i);
      ofs = j - int'(keep);
      if (src < int'(count_q))
        mem_d[j] = mem_q[src[AW-1:0]];
      else if (ofs >= 0 && ofs < int'(push_n_i))
        mem_d[j] = pdat[ofs[1:0]];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign nxt_count_o = count_d;
  assign nxt_head_o  = mem_d[HEAD_BYTES-1:0];
endmodule

// File: rtl/dsi_lane_distributor.sv
// Splits a packetised byte stream round-robin over 1-4 DSI data lanes.
// Optional DSI_DISTRIB_LP_EN: latch in_lp per packet and drive it on iface_write_strb[4].
module dsi_lane_distributor
  import dsi_pkg::*;
#(
  parameter  int LANES_MAX = DSI_LANES_MAX,
  parameter  int BUF_BYTES = 8,
  localparam int CW        = $clog2(BUF_BYTES + 1)
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic [31:0]            in_data,
  input  logic [3:0]             in_strb,
  input  logic                   in_lp,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             reg_lanes_number,
  input  logic                   lines_active,
  output logic [8*LANES_MAX-1:0] iface_write_data,
  output logic [LANES_MAX:0]     iface_write_strb,
  output logic [LANES_MAX-1:0]   iface_write_rqst,
  output logic [LANES_MAX-1:0]   iface_last_word,
  input  logic                   iface_data_rqst,
  output logic                   busy,
  output logic                   err_underflow
);
  distrib_state_t state_q, state_d;

  logic [CW-1:0] n_lanes_q, n_lanes_d, two_n;
  logic [CW-1:0] count_q, nc, r_len, r_next;
  logic          last_seen_q, last_seen_d, nl;
  logic          beat_vld_q, beat_vld_d, err_q, err_d;
  logic          accept, pop_go, cur_final, nfinal, avail, tail_next, lp_flag;
  logic [2:0]    push_n, pop_n;

  logic [LANES_MAX-1:0][7:0] nxt_head, lane_byte, data_q, data_d;
  logic [LANES_MAX-1:0]      lane_on, lane_last;
  logic [LANES_MAX-1:0]      strb_q, strb_d, rqst_q, rqst_d, last_q, last_d;

  assign in_ready = (state_q == FILL || state_q == STREAM) &&
                    (count_q <= CW'(BUF_BYTES - 4)) && !last_seen_q;
  assign accept   = in_valid && in_ready;
  assign push_n   = accept ? (in_last ? strb_bytes(in_strb) : 3'd4) : 3'd0;
  assign nl       = last_seen_q || (accept && in_last);
  assign two_n    = n_lanes_q << 1;

  // The presented beat is the buffer head whenever beat_vld_q is set.
  assign cur_final = last_seen_q && (count_q <= n_lanes_q);
  assign pop_go    = (state_q == STREAM) && iface_data_rqst && beat_vld_q;
  assign pop_n     = pop_go ? (cur_final ? count_q[2:0] : n_lanes_q[2:0]) : 3'd0;

  dsi_byte_buffer #(.BUF_BYTES(BUF_BYTES), .HEAD_BYTES(LANES_MAX)) u_buf (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .push_n_i    (push_n),
    .push_data_i (in_data),
    .pop_n_i     (pop_n),
    .count_o     (count_q),
    .nxt_count_o (nc),
    .nxt_head_o  (nxt_head)
  );

  // Next beat, judged on post-update buffer contents so it can be registered.
  assign avail     = (nc >= n_lanes_q) || (nl && nc != '0);
  assign nfinal    = nl && (nc <= n_lanes_q);
  assign r_len     = nfinal ? nc : n_lanes_q;
  assign tail_next = nl && !nfinal && (nc < two_n);
  assign r_next    = nc - n_lanes_q;

  for (genvar i = 0; i < LANES_MAX; i++) begin : g_lane
    localparam logic [CW-1:0] IDX = CW'(i);
    assign lane_on[i]   = IDX < r_len;
    // Lanes idle in a short final beat finish on the beat before it.
    assign lane_last[i] = nfinal ? lane_on[i]
                                 : (tail_next && IDX >= r_next && IDX < n_lanes_q);
    assign lane_byte[i] = lane_on[i] ? nxt_head[i] : 8'h00;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (lines_active && in_valid) state_d = FILL;
      FILL:   if (nc >= two_n || nl)        state_d = STREAM;
      STREAM: if (pop_go && cur_final)      state_d = FINISH;
      FINISH: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_lanes_d   = (state_q == IDLE) ? CW'(reg_lanes_number) + CW'(1) : n_lanes_q;
    last_seen_d = (state_q == FILL || state_q == STREAM) ? nl : 1'b0;
    err_d       = pop_go && !cur_final && !avail;
    beat_vld_d  = 1'b0;
    data_d      = data_q;
    strb_d      = strb_q;
    rqst_d      = rqst_q;
    last_d      = last_q;
    if (state_d != STREAM) begin
      data_d = '0;
      strb_d = '0;
      rqst_d = '0;
      last_d = '0;
    end else if (avail) begin
      beat_vld_d = 1'b1;
      data_d     = lane_byte;
      strb_d     = lane_on;
      rqst_d     = lane_on;
      last_d     = lane_last;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      n_lanes_q   <= '0;
      last_seen_q <= 1'b0;
      beat_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      strb_q      <= '0;
      rqst_q      <= '0;
      last_q      <= '0;
    end else begin
      n_lanes_q   <= n_lanes_d;
      last_seen_q <= last_seen_d;
      beat_vld_q  <= beat_vld_d;
      err_q       <= err_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      rqst_q      <= rqst_d;
      last_q      <= last_d;
    end
  end

`ifdef DSI_DISTRIB_LP_EN
  logic lp_q, lp_d;
  assign lp_d = (state_d == IDLE) ? 1'b0 : ((state_q == IDLE) ? in_lp : lp_q);
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) lp_q <= 1'b0;
    else        lp_q <= lp_d;
  end
  assign lp_flag = lp_q;
`else
  // HS-only build: in_lp stays on the port but never reaches the lanes.
  assign lp_flag = in_lp & 1'b0;
`endif

  assign iface_write_data = data_q;
  assign iface_write_strb = {lp_flag, strb_q};
  assign iface_write_rqst = rqst_q;
  assign iface_last_word  = last_q;
  assign busy             = (state_q != IDLE);
  assign err_underflow    = err_q;
endmodule

// File: doc/dsi_lane_distributor.md
# dsi_lane_distributor

Upstream feeder of the DSI lanes controller. Takes a packetised 32-bit byte stream from the packet builder and splits it round-robin across the 1–4 active data lanes. It drives the controller's per-lane request, data, strobe and last-word inputs, and advances one lane-beat per `iface_data_rqst`. It preloads two lane-beats so the final beat, and each lane's last byte, are known before they are presented.

## Interface
- `LANES_MAX`, 4: number of physical data lanes; bus widths derive from it.
- `BUF_BYTES`, 8: byte buffer depth; must be ≥ 2×`LANES_MAX`.
- `clk_sys` input, 1 bit: logic clock. One clock only.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_data` input, 32 bits: packet bytes; byte 0 is in [7:0] and is sent first.
- `in_strb` input, 4 bits: valid bytes, contiguous from bit 0. Honoured only when `in_last`=1; otherwise 4 bytes are taken.
- `in_lp` input, 1 bit: packet mode (0 = HS, 1 = LP). Sampled on the first word.
- `in_last` input, 1 bit: last word of the packet.
- `in_valid` input, 1 bit / `in_ready` output, 1 bit: input handshake. A transfer occurs when both are 1.
- `reg_lanes_number` input, 2 bits: active lanes minus 1. Sampled at packet start.
- `lines_active` input, 1 bit: lanes controller reports clock and lanes are up.
- `iface_write_data` output, 32 bits: lane i byte in [8i+7:8i].
- `iface_write_strb` output, 5 bits: [3:0] = per-lane byte valid; [4] = LP mode flag.
- `iface_write_rqst` output, 4 bits: per-lane transmit request.
- `iface_last_word` output, 4 bits: lane i's current byte is its last in the packet.
- `iface_data_rqst` input, 1 bit: consume the current beat and present the next one.
- `busy` output, 1 bit: state ≠ IDLE.
- `err_underflow` output, 1 bit: one-cycle pulse when `iface_data_rqst` arrives with no next beat available.

## Operation
- N = `reg_lanes_number`+1, latched on IDLE→FILL. Later changes are ignored until the next packet.
- Byte k of the packet goes to lane k mod N, in beat k div N.
- The byte buffer is `BUF_BYTES` deep, with a fill count of 0–8.
- `in_ready` = (state is FILL or STREAM) and (count ≤ `BUF_BYTES`−4) and (`in_last` not yet accepted).
- A push and a pop in the same cycle are both allowed: new count = count + pushed − popped.
- State IDLE: all iface outputs are 0. Go to FILL when `lines_active` and `in_valid` are both 1.
- State FILL: accept words. Go to STREAM when count ≥ 2N, or when the last word has been accepted.
- State STREAM: `iface_write_rqst[i]`=1 for each i<N that has a byte in the current beat.
  - On `iface_data_rqst`, pop the beat (N bytes, or fewer for the final beat).
  - Next beat not yet buffered and packet not complete: hold the outputs and pulse `err_underflow`; the pop still occurs.
- Final beat: R = bytes remaining, 1..N.
  - `iface_write_strb[3:0]` = low R bits set.
  - `iface_write_rqst[i]`=0 for lanes i ≥ R.
- `iface_last_word[i]`:
  - i < R: asserted on the final beat.
  - R ≤ i < N: asserted on the previous beat.
  - A packet shorter than N bytes has a single beat: lanes i ≥ length are never requested.
- `iface_data_rqst` on the final beat leads to state FINISH.
- State FINISH: one cycle with all rqst = 0, then IDLE.
- `lines_active` dropping mid-packet: no effect. Completing or aborting the transfer is the controller's job.
- `iface_data_rqst` in IDLE, FILL or FINISH: ignored, with no error.

## Timing
- Reset values: all outputs 0, state IDLE, count 0.
- All outputs are registered. `in_ready` is decoded from registers only.
- FILL→STREAM: `iface_write_rqst` rises in the cycle after the qualifying word is accepted.
- Beat update: the next beat appears in the cycle after `iface_data_rqst`. Back-to-back `iface_data_rqst` is sustained at 1 beat/cycle when N ≤ 4 and input is streaming.
- Reset assertion mid-packet clears everything immediately. The partial packet is discarded.

## Configuration
- `DSI_DISTRIB_LP_EN` defined: `in_lp` is latched and driven on `iface_write_strb[4]` for the whole packet.
- Not defined: `iface_write_strb[4]` is tied to 0 and `in_lp` is unused; all packets are HS.

## Structure
- Shared package `dsi_pkg`:
  - `distrib_state_t` enum: IDLE, FILL, STREAM, FINISH.
  - `DSI_LANES_MAX` = 4.
  - `DSI_LP_FLAG_BIT` = 4.
- Sub-module `dsi_byte_buffer`:
  - 8-byte buffer with variable push (1–4 bytes) and variable pop (1–4 bytes) per cycle.
  - Outputs the count and the 4-byte head.
- The FSM and lane mapping stay in the top module.

## Test plan
- 4 lanes, 8-byte packet 0x03020100/0x07060504 (last, strb F): beat0 data 0x03020100, rqst 4'hF, last 0; beat1 data 0x07060504, last 4'hF; then FINISH→IDLE.
- 3 lanes, 7 bytes 00..06: beats {00,01,02}, {03,04,05}, {06}. Beat1 last_word 4'b0110; beat2 strb 4'b0001, rqst 4'b0001, last 4'b0001.
- 1 lane, 5 bytes: five beats on lane 0 only; rqst 4'b0001 throughout; last_word[0] only on the fifth beat.
- 2 lanes, 1-byte packet (strb 4'b0001): single beat, rqst 4'b0001, last 4'b0001, lane 1 never requested.
- 4 lanes, 12 bytes with `in_valid` withheld after word 2, and `iface_data_rqst` on beat1 and again on the following cycle: `err_underflow` pulses once, outputs hold.
- `rst_n` low in STREAM: all outputs 0 asynchronously. Next 4-byte packet on 4 lanes: single clean beat with last 4'hF. `iface_write_strb[4]` = `in_lp` only when built with `DSI_DISTRIB_LP_EN`.
